// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer: retire-PC trace ring with arm/trigger/post-trigger freeze,
// plus saturating cycle/retire/stall/flush counters.
// Optional build macro: TRACE_CNT_CLR_EN adds the CNT_CLR input (counter clear).
module pipe_trace_buffer #(
   parameter int PC_W      = 32,
   parameter int DEPTH     = 16,
   parameter int CNT_W     = 32,
   parameter int POST_TRIG = 4
) (
   input  logic                       CLK,
   input  logic                       RST,
`ifdef TRACE_CNT_CLR_EN
   input  logic                       CNT_CLR,
`endif
   input  logic                       ARM,
   input  logic                       RETIRE_VALID,
   input  logic [PC_W-1:0]            RETIRE_PC,
   input  logic                       STALL,
   input  logic                       FLUSH,
   input  logic                       TRIG_EN,
   input  logic [PC_W-1:0]            TRIG_PC,
   input  logic [$clog2(DEPTH)-1:0]   RD_ADDR,
   output logic [PC_W-1:0]            RD_PC,
   output logic [1:0]                 STATE,
   output logic [$clog2(DEPTH+1)-1:0] COUNT,
   output logic                       DONE,
   output logic [CNT_W-1:0]           CYCLE_CNT,
   output logic [CNT_W-1:0]           RETIRE_CNT,
   output logic [CNT_W-1:0]           STALL_CNT,
   output logic [CNT_W-1:0]           FLUSH_CNT
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_POST   = 2'd2,
      ST_FROZEN = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [AW-1:0]   post_cnt_q, post_cnt_d;
   logic [PC_W-1:0] rd_pc_q, rd_pc_d;
   logic            wr_en;
   logic [AW-1:0]   rd_idx;

   logic [PC_W-1:0] mem [DEPTH];

   // Capture FSM: arm/clear, store retires, detect trigger, count post-trigger retires.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      post_cnt_d = post_cnt_q;
      wr_en      = 1'b0;
      if (ARM) begin
         // Arming always restarts the trace; a same-cycle retire is dropped.
         state_d    = ST_ARMED;
         wr_ptr_d   = '0;
         count_d    = '0;
         post_cnt_d = '0;
      end else begin
         case (state_q)
            ST_ARMED: begin
               if (RETIRE_VALID) begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  count_d  = (count_q == CW'(DEPTH)) ? count_q : count_q + 1'b1;
                  if (TRIG_EN && (RETIRE_PC == TRIG_PC)) begin
                     post_cnt_d = '0;
                     state_d    = (POST_TRIG == 0) ? ST_FROZEN : ST_POST;
                  end
               end
            end
            ST_POST: begin
               if (RETIRE_VALID) begin
                  wr_en      = 1'b1;
                  wr_ptr_d   = wr_ptr_q + 1'b1;
                  count_d    = (count_q == CW'(DEPTH)) ? count_q : count_q + 1'b1;
                  post_cnt_d = post_cnt_q + 1'b1;
                  if (({1'b0, post_cnt_q} + 1'b1) == (AW + 1)'(POST_TRIG)) begin
                     state_d = ST_FROZEN;
                  end
               end
            end
            default: begin
               // IDLE and FROZEN hold everything until ARM.
            end
         endcase
      end
   end

   // Trace state registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         post_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         post_cnt_q <= post_cnt_d;
      end
   end

   // Trace RAM write port; contents are deliberately not reset.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= RETIRE_PC;
      end
   end

   // Readout: index 0 is the oldest live entry; out-of-range reads return 0.
   always_comb begin
      rd_idx  = wr_ptr_q - count_q[AW-1:0] + RD_ADDR;
      rd_pc_d = '0;
      if (CW'(RD_ADDR) < count_q) begin
         rd_pc_d = mem[rd_idx];
      end
   end

   // Registered read data; a same-edge write is not visible (read-before-write).
   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_pc_q <= '0;
      end else begin
         rd_pc_q <= rd_pc_d;
      end
   end

   // Performance counters: 0 cycle, 1 retire, 2 stall, 3 flush.
   logic [3:0]       cnt_inc;
   logic [CNT_W-1:0] cnt_vec [4];

   assign cnt_inc = {FLUSH, STALL, RETIRE_VALID, 1'b1};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
         logic [CNT_W-1:0] cnt_q, cnt_d;

         // Saturating increment, with optional synchronous clear taking priority.
         always_comb begin
            cnt_d = cnt_q;
            if (cnt_inc[gi] && (cnt_q != {CNT_W{1'b1}})) begin
               cnt_d = cnt_q + 1'b1;
            end
`ifdef TRACE_CNT_CLR_EN
            if (CNT_CLR) begin
               cnt_d = '0;
            end
`endif
         end

         // Counter register.
         always_ff @(posedge CLK) begin
            if (RST) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign cnt_vec[gi] = cnt_q;
      end
   endgenerate

   assign RD_PC      = rd_pc_q;
   assign STATE      = state_q;
   assign COUNT      = count_q;
   assign DONE       = (state_q == ST_FROZEN);
   assign CYCLE_CNT  = cnt_vec[0];
   assign RETIRE_CNT = cnt_vec[1];
   assign STALL_CNT  = cnt_vec[2];
   assign FLUSH_CNT  = cnt_vec[3];

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Scoreboard bench for pipe_trace_buffer: stimulus pushes expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipe_trace_buffer;

   logic        CLK;
   logic        RST;
   logic        ARM;
   logic        RETIRE_VALID;
   logic [31:0] RETIRE_PC;
   logic        STALL;
   logic        FLUSH;
   logic        TRIG_EN;
   logic [31:0] TRIG_PC;
   logic [3:0]  RD_ADDR;
`ifdef TRACE_CNT_CLR_EN
   logic        CNT_CLR;
`endif

   logic [31:0] RD_PC;
   logic [1:0]  STATE;
   logic [4:0]  COUNT;
   logic        DONE;
   logic [31:0] CYCLE_CNT, RETIRE_CNT, STALL_CNT, FLUSH_CNT;

   // Second instance with narrow counters for the saturation check.
   logic [31:0] s_rd_pc;
   logic [1:0]  s_state;
   logic [4:0]  s_count;
   logic        s_done;
   logic [3:0]  s_cycle, s_retire, s_stall, s_flush;

   pipe_trace_buffer #(.PC_W(32), .DEPTH(16), .CNT_W(32), .POST_TRIG(4)) dut (
      .CLK(CLK), .RST(RST),
`ifdef TRACE_CNT_CLR_EN
      .CNT_CLR(CNT_CLR),
`endif
      .ARM(ARM), .RETIRE_VALID(RETIRE_VALID), .RETIRE_PC(RETIRE_PC),
      .STALL(STALL), .FLUSH(FLUSH), .TRIG_EN(TRIG_EN), .TRIG_PC(TRIG_PC),
      .RD_ADDR(RD_ADDR), .RD_PC(RD_PC), .STATE(STATE), .COUNT(COUNT), .DONE(DONE),
      .CYCLE_CNT(CYCLE_CNT), .RETIRE_CNT(RETIRE_CNT), .STALL_CNT(STALL_CNT),
      .FLUSH_CNT(FLUSH_CNT)
   );

   pipe_trace_buffer #(.PC_W(32), .DEPTH(16), .CNT_W(4), .POST_TRIG(4)) dut_small (
      .CLK(CLK), .RST(RST),
`ifdef TRACE_CNT_CLR_EN
      .CNT_CLR(CNT_CLR),
`endif
      .ARM(ARM), .RETIRE_VALID(RETIRE_VALID), .RETIRE_PC(RETIRE_PC),
      .STALL(STALL), .FLUSH(FLUSH), .TRIG_EN(TRIG_EN), .TRIG_PC(TRIG_PC),
      .RD_ADDR(RD_ADDR), .RD_PC(s_rd_pc), .STATE(s_state), .COUNT(s_count), .DONE(s_done),
      .CYCLE_CNT(s_cycle), .RETIRE_CNT(s_retire), .STALL_CNT(s_stall),
      .FLUSH_CNT(s_flush)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      int          sel;
      logic [63:0] exp_val;
      string       name;
   } chk_t;

   chk_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   localparam int S_STATE = 0, S_COUNT = 1, S_DONE = 2, S_RDPC = 3, S_CYC = 4,
                  S_RET = 5, S_STL = 6, S_FLS = 7, S_SCYC = 8;

   task automatic push_exp(input int sel, input logic [63:0] v, input string n);
      chk_t c;
      c.sel = sel; c.exp_val = v; c.name = n;
      sb_q.push_back(c);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic retire(input logic [31:0] pc);
      RETIRE_VALID = 1'b1;
      RETIRE_PC    = pc;
      step();
      RETIRE_VALID = 1'b0;
   endtask

   // Monitor: registered outputs are stable at the falling edge.
   always @(negedge CLK) begin
      while (sb_q.size() > 0) begin
         chk_t        c;
         logic [63:0] act;
         c = sb_q.pop_front();
         case (c.sel)
            S_STATE: act = 64'(STATE);
            S_COUNT: act = 64'(COUNT);
            S_DONE:  act = 64'(DONE);
            S_RDPC:  act = 64'(RD_PC);
            S_CYC:   act = 64'(CYCLE_CNT);
            S_RET:   act = 64'(RETIRE_CNT);
            S_STL:   act = 64'(STALL_CNT);
            S_FLS:   act = 64'(FLUSH_CNT);
            default: act = 64'(s_cycle);
         endcase
         n_checks++;
         if (act !== c.exp_val) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", c.name, act, c.exp_val, $time);
         end else begin
            $display("check %s: 0x%0h ok", c.name, act);
         end
      end
   end

   initial begin
      logic [9:0] stall_v, flush_v, ret_v;
      int         drain;

      RST = 1'b1; ARM = 1'b0; RETIRE_VALID = 1'b0; RETIRE_PC = '0;
      STALL = 1'b0; FLUSH = 1'b0; TRIG_EN = 1'b0; TRIG_PC = '0; RD_ADDR = '0;
`ifdef TRACE_CNT_CLR_EN
      CNT_CLR = 1'b0;
`endif

      // Reset held for two edges.
      step(); step();
      push_exp(S_STATE, 0, "rst_state");
      push_exp(S_COUNT, 0, "rst_count");
      push_exp(S_DONE,  0, "rst_done");
      push_exp(S_RDPC,  0, "rst_rd_pc");
      push_exp(S_CYC,   0, "rst_cycle");
      push_exp(S_RET,   0, "rst_retire");
      push_exp(S_STL,   0, "rst_stall");
      push_exp(S_FLS,   0, "rst_flush");
      RST = 1'b0;
      step();
      push_exp(S_CYC, 1, "cycle_after_rst");

      // Counters: 10 cycles, stall x3, flush x2, retire x5 (bit 2 overlaps stall).
      stall_v = 10'b0000000111;
      flush_v = 10'b0000110000;
      ret_v   = 10'b1111000100;
      for (int i = 0; i < 10; i++) begin
         STALL        = stall_v[i];
         FLUSH        = flush_v[i];
         RETIRE_VALID = ret_v[i];
         RETIRE_PC    = 32'h1000 + 32'(i);
         step();
      end
      STALL = 1'b0; FLUSH = 1'b0; RETIRE_VALID = 1'b0;
      push_exp(S_STL,   3,  "cnt_stall");
      push_exp(S_FLS,   2,  "cnt_flush");
      push_exp(S_RET,   5,  "cnt_retire");
      push_exp(S_CYC,   11, "cnt_cycle");
      push_exp(S_COUNT, 0,  "idle_no_store");

      // Wrap: 18 retires without trigger.
      ARM = 1'b1; step(); ARM = 1'b0;
      push_exp(S_STATE, 1, "armed_state");
      push_exp(S_COUNT, 0, "armed_count");
      for (int i = 0; i < 18; i++) retire(32'(i * 4));
      RD_ADDR = 4'd0; step();
      push_exp(S_STATE, 1,     "wrap_state");
      push_exp(S_COUNT, 16,    "wrap_count");
      push_exp(S_RET,   23,    "wrap_retire_cnt");
      push_exp(S_RDPC,  32'h08, "wrap_rd0");
      push_exp(S_SCYC,  15,    "small_cycle_sat");
      RD_ADDR = 4'd15; step();
      push_exp(S_RDPC,  32'h44, "wrap_rd15");

      // Trigger at 0x20, four post-trigger retires, then freeze.
      ARM = 1'b1; step(); ARM = 1'b0;
      TRIG_EN = 1'b1; TRIG_PC = 32'h20;
      for (int i = 0; i < 17; i++) retire(32'(i * 4));
      RD_ADDR = 4'd12; step();
      push_exp(S_STATE, 3,      "trig_state");
      push_exp(S_DONE,  1,      "trig_done");
      push_exp(S_COUNT, 13,     "trig_count");
      push_exp(S_RDPC,  32'h30, "trig_rd12");
      RD_ADDR = 4'd13; step();
      push_exp(S_RDPC,  0,      "trig_rd13");
      RD_ADDR = 4'd8; step();
      push_exp(S_RDPC,  32'h20, "trig_rd8");
      push_exp(S_RET,   40,     "trig_retire_cnt");

      // Abort: reset while in POST.
      ARM = 1'b1; step(); ARM = 1'b0;
      for (int i = 0; i < 9; i++) retire(32'(i * 4));
      push_exp(S_STATE, 2, "post_state");
      push_exp(S_COUNT, 9, "post_count");
      RST = 1'b1; RETIRE_VALID = 1'b1; RETIRE_PC = 32'h24;
      step();
      RST = 1'b0; RETIRE_VALID = 1'b0;
      push_exp(S_STATE, 0, "abort_state");
      push_exp(S_COUNT, 0, "abort_count");
      push_exp(S_RDPC,  0, "abort_rd_pc");
      push_exp(S_RET,   0, "abort_retire_cnt");

      // Race: ARM with a same-cycle retire drops that PC.
      TRIG_EN = 1'b0;
      ARM = 1'b1; RETIRE_VALID = 1'b1; RETIRE_PC = 32'h100;
      step();
      ARM = 1'b0; RETIRE_VALID = 1'b0;
      push_exp(S_STATE, 1, "race_state");
      push_exp(S_COUNT, 0, "race_count");
      push_exp(S_RET,   1, "race_retire_cnt");
      RD_ADDR = 4'd0; step();
      push_exp(S_RDPC,  0, "race_rd0");
      retire(32'h200);
      push_exp(S_COUNT, 1, "one_store_count");

`ifdef TRACE_CNT_CLR_EN
      // Counter clear beats a same-cycle stall; trace is untouched.
      STALL = 1'b1; CNT_CLR = 1'b1; step();
      STALL = 1'b0; CNT_CLR = 1'b0;
      push_exp(S_CYC,   0, "clr_cycle");
      push_exp(S_STL,   0, "clr_stall");
      push_exp(S_RET,   0, "clr_retire");
      push_exp(S_FLS,   0, "clr_flush");
      push_exp(S_COUNT, 1, "clr_trace_count");
      step();
      push_exp(S_CYC,   1, "clr_cycle_next");
`endif

      // Let the monitor drain the scoreboard, bounded.
      drain = 0;
      while (sb_q.size() > 0 && drain < 10) begin
         step();
         drain++;
      end
      if (sb_q.size() > 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
